// File: rtl/lut_pkg.sv
// Shared constants and state encoding for the SR LUT write-side loader.
package lut_pkg;

    localparam int LUT_DEPTH    = 3392;
    localparam int LUT_ADDR_W   = 12;
    localparam int LUT_DATA_W   = 32;
    localparam int LUT_ADDR_OFS = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_EVEN = 3'd1,
        GET_ODD  = 3'd2,
        ISSUE    = 3'd3,
        FINISH   = 3'd4
    } lut_state_t;

endpackage

// File: rtl/lut_loader.sv
// Streams 32-bit LUT words into paired dual-port SRAM writes (even entries on port 1,
// odd entries on port 2), then raises SR_start to hand the bank to the read path.
module lut_loader
    import lut_pkg::*;
#(
    parameter int DEPTH    = LUT_DEPTH,
    parameter int ADDR_W   = LUT_ADDR_W,
    parameter int DATA_W   = LUT_DATA_W,
    parameter int ADDR_OFS = LUT_ADDR_OFS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [ADDR_W-1:0] addr1,
    output logic [ADDR_W-1:0] addr2,
    output logic              LUT_WE,
    output logic              SR_start,
    output logic              busy,
    output logic              done
);

    localparam int PAIRS = DEPTH / 2;
    localparam int K_W   = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(PAIRS - 1);

    lut_state_t        r_state;
    lut_state_t        w_next;
    logic [K_W-1:0]    r_k;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_data1;
    logic [DATA_W-1:0] r_data2;
    logic [ADDR_W-1:0] r_addr1;
    logic [ADDR_W-1:0] r_addr2;
    logic              r_we_n;
    logic              r_sr_start;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_done;

    logic              w_hs;
    logic              w_abort;
    logic              w_start;
    logic [ADDR_W-1:0] w_addr1;

    assign w_hs    = in_valid & r_in_ready;
    assign w_abort = load_abort & (r_state != IDLE);
    assign w_start = load_start & ~load_abort & (r_state == IDLE);
    // Address arithmetic wraps modulo 2^ADDR_W by construction.
    assign w_addr1 = ADDR_W'({r_k, 1'b0}) + ADDR_W'(ADDR_OFS);

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:     if (w_start) w_next = GET_EVEN;
                GET_EVEN: if (w_hs) w_next = GET_ODD;
                GET_ODD:  if (w_hs) w_next = ISSUE;
                ISSUE:    w_next = (r_k == K_LAST) ? FINISH : GET_EVEN;
                FINISH:   w_next = IDLE;
                default:  w_next = IDLE;
            endcase
        end
    end

    // in_ready/busy are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_k        <= '0;
            r_hold     <= '0;
            r_data1    <= '0;
            r_data2    <= '0;
            r_addr1    <= '0;
            r_addr2    <= '0;
            r_we_n     <= 1'b1;
            r_sr_start <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next == GET_EVEN) || (w_next == GET_ODD);
            r_busy     <= (w_next != IDLE);
            r_we_n     <= 1'b1;
            r_done     <= 1'b0;
            if (w_abort) begin
                r_sr_start <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_start) begin
                            r_k        <= '0;
                            r_sr_start <= 1'b0;
                        end
                    end
                    GET_EVEN: begin
                        if (w_hs) r_hold <= in_data;
                    end
                    GET_ODD: begin
                        if (w_hs) begin
                            r_data1 <= r_hold;
                            r_data2 <= in_data;
                        end
                    end
                    ISSUE: begin
                        r_addr1 <= w_addr1;
                        r_addr2 <= w_addr1 + ADDR_W'(1);
                        r_we_n  <= 1'b0;
                        if (r_k != K_LAST) r_k <= r_k + K_W'(1);
                    end
                    FINISH: begin
                        r_done     <= 1'b1;
                        r_sr_start <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready = r_in_ready;
    assign data1    = r_data1;
    assign data2    = r_data2;
    assign addr1    = r_addr1;
    assign addr2    = r_addr2;
    assign LUT_WE   = r_we_n;
    assign SR_start = r_sr_start;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
